// File: rtl/rocc_cmd_queue_pkg.sv
// Shared types and widths for the RoCC command queue.
// rocc_cmd_t gives the field order used when a command is packed into a FIFO word.
package rocc_cmd_queue_pkg;

  localparam int FUNCT_W  = 7;
  localparam int RD_W     = 5;
  localparam int CMD_XLEN = 64;

  typedef struct packed {
    logic [FUNCT_W-1:0]  funct;
    logic [RD_W-1:0]     rd;
    logic                xd;
    logic [CMD_XLEN-1:0] rs1;
    logic [CMD_XLEN-1:0] rs2;
  } rocc_cmd_t;

endpackage

// File: rtl/rocc_cmd_fifo.sv
// Generic registered FIFO with a synchronous flush and an occupancy count.
// There is no write-to-read bypass: a pushed word reaches head_data one cycle later.
module rocc_cmd_fifo
  import rocc_cmd_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/rocc_cmd_queue.sv
// Decoupling queue between core RoCC ports and an accelerator: command FIFO, xd=1 outstanding cap,
// one-entry response register, exception flush. Define ROCC_CMD_QUEUE_STATS_EN to add issue/response counters.
// Handshakes: a transfer happens on a cycle where valid && ready are both high at the rising clock edge.
module rocc_cmd_queue
  import rocc_cmd_queue_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               core_cmd_valid,
  output logic               core_cmd_ready,
  input  logic [FUNCT_W-1:0] core_cmd_funct,
  input  logic [RD_W-1:0]    core_cmd_rd,
  input  logic               core_cmd_xd,
  input  logic [XLEN-1:0]    core_cmd_rs1,
  input  logic [XLEN-1:0]    core_cmd_rs2,
  output logic               acc_cmd_valid,
  input  logic               acc_cmd_ready,
  output logic [FUNCT_W-1:0] acc_cmd_funct,
  output logic [RD_W-1:0]    acc_cmd_rd,
  output logic               acc_cmd_xd,
  output logic [XLEN-1:0]    acc_cmd_rs1,
  output logic [XLEN-1:0]    acc_cmd_rs2,
  input  logic               acc_resp_valid,
  output logic               acc_resp_ready,
  input  logic [RD_W-1:0]    acc_resp_rd,
  input  logic [XLEN-1:0]    acc_resp_data,
  output logic               core_resp_valid,
  input  logic               core_resp_ready,
  output logic [RD_W-1:0]    core_resp_rd,
  output logic [XLEN-1:0]    core_resp_data,
  input  logic               exception,
  output logic               busy,
  output logic               protocol_err
`ifdef ROCC_CMD_QUEUE_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_responded
`endif
);

  localparam int CMD_W = FUNCT_W + RD_W + 1 + 2 * XLEN;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CMD_W-1:0] head_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push, fifo_pop;
  logic             resp_hs, core_hs, issue_xd;

  logic [OUT_W-1:0] outst_q, outst_d;
  logic             perr_q, perr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [RD_W-1:0]  resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;

  rocc_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (exception),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ({core_cmd_funct, core_cmd_rd, core_cmd_xd, core_cmd_rs1, core_cmd_rs2}),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign {acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2} = head_data;

  assign core_cmd_ready = (fifo_count != CNT_W'(DEPTH)) && !exception;
  // Only write-back commands count against the cap; xd=0 commands always pass.
  assign acc_cmd_valid  = (fifo_count != '0)
                          && !(acc_cmd_xd && (outst_q == OUT_W'(MAX_OUTSTANDING)))
                          && !exception;
  assign acc_resp_ready = !resp_valid_q || core_resp_ready;

  assign fifo_push = core_cmd_valid && core_cmd_ready;
  assign fifo_pop  = acc_cmd_valid && acc_cmd_ready;
  assign issue_xd  = fifo_pop && acc_cmd_xd;
  assign resp_hs   = acc_resp_valid && acc_resp_ready;
  assign core_hs   = resp_valid_q && core_resp_ready;

  always_comb begin
    outst_d = outst_q;
    perr_d  = perr_q || (resp_hs && (outst_q == '0));
    // A stray response never drives the counter below zero.
    if (issue_xd && !resp_hs) outst_d = outst_q + 1'b1;
    else if (!issue_xd && resp_hs && (outst_q != '0)) outst_d = outst_q - 1'b1;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    if (resp_hs) begin
      resp_valid_d = 1'b1;
      resp_rd_d    = acc_resp_rd;
      resp_data_d  = acc_resp_data;
    end else if (core_hs) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outst_q      <= '0;
      perr_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      outst_q      <= outst_d;
      perr_q       <= perr_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign core_resp_valid = resp_valid_q;
  assign core_resp_rd    = resp_rd_q;
  assign core_resp_data  = resp_data_q;
  assign protocol_err    = perr_q;
  assign busy            = (fifo_count != '0) || (outst_q != '0) || resp_valid_q;

`ifdef ROCC_CMD_QUEUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_responded_q, stat_responded_d;

  always_comb begin
    stat_issued_d    = stat_issued_q + {31'd0, fifo_pop};
    stat_responded_d = stat_responded_q + {31'd0, core_hs};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_issued_q    <= '0;
      stat_responded_q <= '0;
    end else begin
      stat_issued_q    <= stat_issued_d;
      stat_responded_q <= stat_responded_d;
    end
  end

  assign stat_issued    = stat_issued_q;
  assign stat_responded = stat_responded_q;
`endif

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Self-checking bench for rocc_cmd_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_rocc_cmd_queue;
  import rocc_cmd_queue_pkg::*;

  localparam int XLEN    = 64;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic            clock, reset;
  logic            core_cmd_valid, core_cmd_ready;
  logic [6:0]      core_cmd_funct;
  logic [4:0]      core_cmd_rd;
  logic            core_cmd_xd;
  logic [XLEN-1:0] core_cmd_rs1, core_cmd_rs2;
  logic            acc_cmd_valid, acc_cmd_ready;
  logic [6:0]      acc_cmd_funct;
  logic [4:0]      acc_cmd_rd;
  logic            acc_cmd_xd;
  logic [XLEN-1:0] acc_cmd_rs1, acc_cmd_rs2;
  logic            acc_resp_valid, acc_resp_ready;
  logic [4:0]      acc_resp_rd;
  logic [XLEN-1:0] acc_resp_data;
  logic            core_resp_valid, core_resp_ready;
  logic [4:0]      core_resp_rd;
  logic [XLEN-1:0] core_resp_data;
  logic            exception, busy, protocol_err;
`ifdef ROCC_CMD_QUEUE_STATS_EN
  logic [31:0]     stat_issued, stat_responded;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  rocc_cmd_t   mq[$];
  int          m_outst;
  bit          m_rv, m_err, m_last_push;
  logic [4:0]  m_rrd;
  logic [63:0] m_rdata;
  int unsigned m_issued, m_responded;

  rocc_cmd_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .core_cmd_valid(core_cmd_valid), .core_cmd_ready(core_cmd_ready),
    .core_cmd_funct(core_cmd_funct), .core_cmd_rd(core_cmd_rd), .core_cmd_xd(core_cmd_xd),
    .core_cmd_rs1(core_cmd_rs1), .core_cmd_rs2(core_cmd_rs2),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
    .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
    .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
    .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_rd(core_resp_rd), .core_resp_data(core_resp_data),
    .exception(exception), .busy(busy), .protocol_err(protocol_err)
`ifdef ROCC_CMD_QUEUE_STATS_EN
    , .stat_issued(stat_issued), .stat_responded(stat_responded)
`endif
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    core_cmd_valid = 0; core_cmd_funct = '0; core_cmd_rd = '0; core_cmd_xd = 0;
    core_cmd_rs1 = '0; core_cmd_rs2 = '0;
    acc_cmd_ready = 0; acc_resp_valid = 0; acc_resp_rd = '0; acc_resp_data = '0;
    core_resp_ready = 1; exception = 0;
  endtask

  task automatic set_cmd(input int f, input int r, input bit x, input logic [63:0] a, input logic [63:0] b);
    core_cmd_valid = 1; core_cmd_funct = 7'(f); core_cmd_rd = 5'(r); core_cmd_xd = x;
    core_cmd_rs1 = a; core_cmd_rs2 = b;
  endtask

  task automatic model_clear();
    mq.delete(); m_outst = 0; m_rv = 0; m_err = 0; m_rrd = '0; m_rdata = '0;
    m_last_push = 0; m_issued = 0; m_responded = 0;
  endtask

  // Called just after a falling edge with inputs set: check outputs, then advance the model one edge.
  task automatic step();
    bit e_cmd_ready, e_acc_valid, e_resp_ready, e_busy;
    bit push, pop, rsp, chs, pop_xd;
    rocc_cmd_t c;
    #1;
    e_cmd_ready = (mq.size() < DEPTH) && !exception;
    e_acc_valid = 0;
    if (mq.size() > 0 && !exception) e_acc_valid = !(mq[0].xd && m_outst == MAX_OUT);
    e_resp_ready = !m_rv || core_resp_ready;
    e_busy = (mq.size() > 0) || (m_outst > 0) || m_rv;
    check("core_cmd_ready", core_cmd_ready, e_cmd_ready);
    check("acc_cmd_valid", acc_cmd_valid, e_acc_valid);
    check("acc_resp_ready", acc_resp_ready, e_resp_ready);
    check("core_resp_valid", core_resp_valid, m_rv);
    check("busy", busy, e_busy);
    check("protocol_err", protocol_err, m_err);
    if (e_acc_valid) begin
      check("acc_cmd_funct", acc_cmd_funct, mq[0].funct);
      check("acc_cmd_rd", acc_cmd_rd, mq[0].rd);
      check("acc_cmd_xd", acc_cmd_xd, mq[0].xd);
      check("acc_cmd_rs1", acc_cmd_rs1, mq[0].rs1);
      check("acc_cmd_rs2", acc_cmd_rs2, mq[0].rs2);
    end
    if (m_rv) begin
      check("core_resp_rd", core_resp_rd, m_rrd);
      check("core_resp_data", core_resp_data, m_rdata);
    end
`ifdef ROCC_CMD_QUEUE_STATS_EN
    check("stat_issued", stat_issued, m_issued);
    check("stat_responded", stat_responded, m_responded);
`endif
    push = core_cmd_valid && e_cmd_ready;
    pop  = e_acc_valid && acc_cmd_ready;
    rsp  = acc_resp_valid && e_resp_ready;
    chs  = m_rv && core_resp_ready;
    pop_xd = pop ? mq[0].xd : 1'b0;
    @(posedge clock);
    if (exception) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        c.funct = core_cmd_funct; c.rd = core_cmd_rd; c.xd = core_cmd_xd;
        c.rs1 = core_cmd_rs1; c.rs2 = core_cmd_rs2;
        mq.push_back(c);
      end
    end
    if (rsp && m_outst == 0) m_err = 1;
    if (pop_xd && !rsp) m_outst++;
    else if (!pop_xd && rsp && m_outst > 0) m_outst--;
    if (rsp) begin
      m_rv = 1; m_rrd = acc_resp_rd; m_rdata = acc_resp_data;
    end else if (chs) m_rv = 0;
    if (pop) m_issued++;
    if (chs) m_responded++;
    m_last_push = push;
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    #1;
    check("rst_core_cmd_ready", core_cmd_ready, 1);
    check("rst_acc_cmd_valid", acc_cmd_valid, 0);
    check("rst_acc_resp_ready", acc_resp_ready, 1);
    check("rst_core_resp_valid", core_resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_protocol_err", protocol_err, 0);
    check("rst_core_resp_data", core_resp_data, 0);
    check("rst_acc_cmd_rs1", acc_cmd_rs1, 0);
    repeat (2) @(negedge clock);
    model_clear();
    reset = 1;
  endtask

  task automatic drain();
    bit done;
    idle();
    acc_cmd_ready = 1;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      acc_resp_valid = (m_outst > 0);
      acc_resp_rd = 5'($urandom); acc_resp_data = {$urandom, $urandom};
      if (mq.size() == 0 && m_outst == 0 && !m_rv) done = 1;
      else step();
    end
    idle();
    check("drain_done", done, 1);
  endtask

  initial begin
    reset = 0;
    idle();
    model_clear();
    @(negedge clock);
    do_reset();
    @(negedge clock);

    // 1. Smoke path
    acc_cmd_ready = 1;
    set_cmd(3, 5, 1, 64'd10, 64'd20);
    step();
    core_cmd_valid = 0;
    #1;
    check("smoke_valid", acc_cmd_valid, 1);
    check("smoke_funct", acc_cmd_funct, 3);
    check("smoke_rs1", acc_cmd_rs1, 10);
    check("smoke_rs2", acc_cmd_rs2, 20);
    step();
    acc_cmd_ready = 0;
    acc_resp_valid = 1; acc_resp_rd = 5; acc_resp_data = 64'd30;
    step();
    acc_resp_valid = 0;
    #1;
    check("smoke_resp_valid", core_resp_valid, 1);
    check("smoke_resp_data", core_resp_data, 30);
    step();
    #1;
    check("smoke_busy_low", busy, 0);

    // 2. Full FIFO, in-order release
    for (int i = 1; i <= 4; i++) begin
      set_cmd(i, i, 0, 64'(i), 64'(i * 100));
      step();
    end
    set_cmd(5, 5, 0, 64'd5, 64'd500);
    #1;
    check("full_ready_low", core_cmd_ready, 0);
    step();
    acc_cmd_ready = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_last_push) core_cmd_valid = 0;
    end
    drain();

    // 3. Outstanding cap
    acc_cmd_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(9, i, 1, 64'(i + 40), 64'(i));
      step();
    end
    core_cmd_valid = 0;
    repeat (3) step();
    #1;
    check("cap_blocked", acc_cmd_valid, 0);
    check("cap_busy", busy, 1);
    acc_resp_valid = 1; acc_resp_rd = 1; acc_resp_data = 64'hAB;
    step();
    acc_resp_valid = 0;
    #1;
    check("cap_fifth_issues", acc_cmd_valid, 1);
    check("cap_fifth_rs1", acc_cmd_rs1, 44);
    step();
    set_cmd(2, 7, 0, 64'h77, 64'h0);
    step();
    core_cmd_valid = 0;
    #1;
    check("cap_xd0_bypass", acc_cmd_valid, 1);
    step();

    // 4. Flush with a response in flight
    acc_cmd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, i, 0, 64'(i), 64'(i));
      step();
    end
    exception = 1;
    set_cmd(1, 9, 0, 64'h99, 64'h99);
    acc_resp_valid = 1; acc_resp_rd = 3; acc_resp_data = 64'hC0FFEE;
    #1;
    check("flush_ready_low", core_cmd_ready, 0);
    step();
    exception = 0; core_cmd_valid = 0; acc_resp_valid = 0; core_resp_ready = 0;
    #1;
    check("flush_acc_valid", acc_cmd_valid, 0);
    check("flush_resp_kept", core_resp_valid, 1);
    check("flush_resp_data", core_resp_data, 64'hC0FFEE);
    core_resp_ready = 1;
    step();

    // 5. Response backpressure
    core_resp_ready = 0;
    acc_resp_valid = 1; acc_resp_rd = 10; acc_resp_data = 64'hA1;
    step();
    acc_resp_rd = 11; acc_resp_data = 64'hB2;
    #1;
    check("bp_acc_ready_low", acc_resp_ready, 0);
    step();
    core_resp_ready = 1;
    #1;
    check("bp_first_data", core_resp_data, 64'hA1);
    step();
    acc_resp_valid = 0;
    #1;
    check("bp_second_data", core_resp_data, 64'hB2);
    step();
    drain();

    // 6. Protocol error, then reset in mid-stream
    acc_resp_valid = 1; acc_resp_rd = 2; acc_resp_data = 64'h5;
    step();
    acc_resp_valid = 0;
    #1;
    check("perr_set", protocol_err, 1);
    repeat (2) step();
    check("perr_sticky", protocol_err, 1);
    set_cmd(4, 4, 1, 64'h4, 64'h4);
    repeat (2) step();
    do_reset();
    @(negedge clock);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      core_cmd_valid = ($urandom_range(0, 1) == 1);
      core_cmd_funct = 7'($urandom); core_cmd_rd = 5'($urandom);
      core_cmd_xd = ($urandom_range(0, 3) != 0);
      core_cmd_rs1 = {$urandom, $urandom}; core_cmd_rs2 = {$urandom, $urandom};
      acc_cmd_ready = ($urandom_range(0, 3) != 0);
      acc_resp_valid = (m_outst > 0) && ($urandom_range(0, 1) == 1);
      acc_resp_rd = 5'($urandom); acc_resp_data = {$urandom, $urandom};
      core_resp_ready = ($urandom_range(0, 3) != 0);
      exception = ($urandom_range(0, 49) == 0);
      step();
    end
    set_cmd(1, 1, 1, 64'h1, 64'h1);
    step();
    do_reset();
    @(negedge clock);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_queue.md
Name: rocc_cmd_queue

Overview:
Decoupling stage between the core's RoCC command/response ports and a RoCC accelerator (e.g. the accumulator black box). It buffers core commands in a FIFO and issues them to the accelerator. It tracks commands that expect a write-back (xd=1) and caps how many may be outstanding. It registers accelerator responses back to the core and drives a combined busy. A core exception flushes commands that have not yet been issued.

Parameters:
XLEN, 64, width of rs1/rs2/response data
DEPTH, 4, command FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 4, max issued xd=1 commands awaiting response (>=1)

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset
core_cmd_valid  in  1  command from core valid
core_cmd_ready  out  1  FIFO can accept
core_cmd_funct  in  7  inst funct
core_cmd_rd  in  5  destination register
core_cmd_xd  in  1  response expected
core_cmd_rs1  in  XLEN  rs1 value
core_cmd_rs2  in  XLEN  rs2 value
acc_cmd_valid  out  1  command to accelerator valid
acc_cmd_ready  in  1  accelerator accepts
acc_cmd_funct/rd/xd/rs1/rs2  out  7/5/1/XLEN/XLEN  head-of-FIFO fields
acc_resp_valid  in  1  accelerator response valid
acc_resp_ready  out  1  response slot free
acc_resp_rd  in  5  response rd
acc_resp_data  in  XLEN  response data
core_resp_valid  out  1  registered response valid
core_resp_ready  in  1  core accepts
core_resp_rd  out  5  registered rd
core_resp_data  out  XLEN  registered data
exception  in  1  core exception: flush queued commands
busy  out  1  queue non-empty, outstanding>0, or response slot full
protocol_err  out  1  sticky: response arrived with zero outstanding

Behaviour:
- Reset (async assert, sync release) clears FIFO and counters and the response slot. Outputs at reset: core_cmd_ready=1, acc_cmd_valid=0, acc_resp_ready=1, core_resp_valid=0, busy=0, protocol_err=0. Data outputs are 0.
- FIFO storage is registered, with no enqueue-to-dequeue bypass; an entry is visible on acc_cmd_* the cycle after it is enqueued.
  - core_cmd_ready = (count<DEPTH) && !exception.
  - Enqueue and dequeue may happen in the same cycle when 0<count<DEPTH; count is then unchanged.
  - Pointers wrap modulo DEPTH.
- acc_cmd_valid = (count>0) && !(head.xd && outstanding==MAX_OUTSTANDING) && !exception.
  - xd=0 commands are never blocked by the cap.
  - Dequeue happens on acc_cmd_valid && acc_cmd_ready.
- outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on dequeue with xd=1.
  - -1 on acc_resp handshake.
  - Both in the same cycle leaves it unchanged.
  - On a response while outstanding==0: counter holds at 0 and protocol_err is set until reset.
- Response slot is a one-entry pipeline register.
  - acc_resp_ready = !full || core_resp_ready.
  - Load on acc handshake. Clear when core handshakes with no new load.
  - Latency is 1 cycle; throughput is 1 per cycle when core_resp_ready stays high.
- exception (level): the next edge sets count=0 and resets the pointers.
  - Enqueue and dequeue are suppressed in the exception cycle.
  - outstanding and the response slot are unaffected; in-flight responses still return.
- busy = (count>0) || (outstanding>0) || core_resp_valid, registered-free (combinational from state).
- Mid-operation reset drops all contents with no response emitted.

Optional Feature:
ROCC_CMD_QUEUE_STATS_EN
- Defined: adds outputs stat_issued[31:0] and stat_responded[31:0], both wrapping 32-bit counters reset to 0.
  - stat_issued increments per acc_cmd handshake.
  - stat_responded increments per core_resp handshake.
  - Flushed entries are not counted.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rocc_cmd_queue_pkg holds:
  - the rocc_cmd_t struct (funct, rd, xd, rs1, rs2), parameterised on XLEN via localparam default 64;
  - the width constants FUNCT_W=7 and RD_W=5.
- Sub-module rocc_cmd_fifo: generic DEPTH FIFO with flush, count output, no bypass. The outstanding counter and response slot stay in the top.

Test Plan:
1. Smoke path: enqueue funct=3, rd=5, xd=1, rs1=10, rs2=20 with acc_cmd_ready=1.
   -> acc_cmd_valid rises 1 cycle later with the same fields; outstanding=1.
   -> Accelerator responds rd=5, data=30; core_resp_valid with data=30 the next cycle.
   -> busy falls after the core handshake.
2. Full FIFO: hold acc_cmd_ready=0 and enqueue 5 commands.
   -> core_cmd_ready=0 after the 4th; the 5th is held.
   -> Release: commands exit in order 1..4, then the 5th is accepted.
3. Outstanding cap: 5 xd=1 commands with no responses.
   -> Exactly 4 are issued and acc_cmd_valid=0 with 1 queued.
   -> One response lets the 5th issue on the same cycle the counter decrements.
   -> An xd=0 command at the head issues regardless of the cap.
4. Flush: 3 queued commands, then exception for 1 cycle.
   -> count=0 and acc_cmd_valid=0 next cycle.
   -> A core_cmd_valid during the exception cycle sees ready=0.
   -> A pending response is still delivered.
5. Response backpressure: core_resp_ready=0 with two accelerator responses.
   -> First is held; acc_resp_ready=0 for the second.
   -> Raising ready delivers both in order on consecutive cycles.
6. Protocol error: acc_resp_valid with no outstanding command.
   -> protocol_err=1 sticky; outstanding stays 0. Assert reset low mid-stream → all outputs return to reset values.
